uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Core-side serial receiver. It is the far end of the host-to-core line that the computer-side IO model drives. Deserialises 8N1 UART frames from the `rxd` pin and buffers the received bytes in a small FIFO. The core fetch/IO unit drains the FIFO through a valid/ready pop interface. It sits inside `core_wrapper` between the `comp_to_core` pin and the core's input-instruction path.

Parameters:
CLK_PER_HALF_BIT, 100, clk cycles per half UART bit; one bit period = 2*CLK_PER_HALF_BIT; must be >= 2
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (default 8)

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
rxd  in  1  serial input, idle high, asynchronous to clk
rdata  out  8  FIFO head byte, valid when rvalid=1
rvalid  out  1  FIFO non-empty
rready  in  1  consumer pop; a pop occurs when rvalid&&rready
count  out  DEPTH_LOG2+1  current FIFO occupancy
ferr  out  1  one-cycle pulse: stop bit sampled low, byte discarded
ovf  out  1  one-cycle pulse: byte completed while FIFO full, byte discarded

Behaviour:
- Reset (async, rstn=0):
  - rdata=0, rvalid=0, count=0, ferr=0, ovf=0.
  - FSM=IDLE, synchroniser flops=1, FIFO pointers=0.
  - Reset mid-frame abandons the partial byte; nothing is pushed.
- Input path: rxd goes through a 2-flop synchroniser (both flops reset to 1). Only the synchronised value, rx_s, is used.
- FSM states: IDLE, START, DATA, STOP. Bit timer counts 0..2*CLK_PER_HALF_BIT-1.
  - IDLE: when rx_s=0, go to START and clear the timer.
  - START: after CLK_PER_HALF_BIT cycles (mid start bit), resample rx_s.
    - rx_s=0: go to DATA, clear timer and bit index.
    - rx_s=1 (glitch): return to IDLE with no error pulse.
  - DATA: every 2*CLK_PER_HALF_BIT cycles, sample rx_s into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: after 2*CLK_PER_HALF_BIT cycles, sample rx_s.
    - rx_s=1: push the byte into the FIFO; if the FIFO is full, drop it and pulse ovf instead.
    - rx_s=0: pulse ferr and do not push.
    - Either way, go to IDLE in the same cycle.
  - The receiver returns to IDLE at mid stop bit, so back-to-back frames with a single stop bit are received.
  - A line held low after a framing error starts a new frame only after a falling edge is seen, i.e. rx_s was 1 for at least one cycle.
- FIFO: circular buffer with wrap-around pointers of DEPTH_LOG2 bits, plus count.
  - rdata is driven from the storage at the read pointer, registered through the FIFO.
  - rvalid=(count!=0).
  - A push becomes visible on rvalid/rdata the cycle after the stop-bit sample. There is no same-cycle bypass.
  - Simultaneous push and pop while full: the push is accepted, no ovf, count unchanged.
  - Simultaneous push and pop while empty: impossible (rvalid=0). The push proceeds and count becomes 1.
  - rready while empty is ignored; count never underflows.
- Latency: from the rxd rising-edge mid stop bit (plus 2 synchroniser cycles) to rvalid=1 is 1 cycle after the STOP sample.
- ferr and ovf are single-cycle pulses and are never asserted together.

Decomposition:
- Shared package: FSM state encoding (`rx_state_t`: IDLE/START/DATA/STOP), `UART_DATA_BITS=8`.
- Natural sub-module `sync_fifo` (width 8, DEPTH_LOG2 parameter) holding storage, pointers and count.
- The receive FSM and timer stay in `uart_rx_fifo`.

Test Plan:
- CLK_PER_HALF_BIT=4, send byte 0xA5 (8N1) -> rvalid rises one cycle after the stop sample; rdata=0xA5, count=1; rready pulse -> rvalid=0, count=0.
- Back-to-back frames 0x01,0x80,0xFF,0x00 with rready=0 -> count=4; popping yields exactly that order; no ferr/ovf.
- Low glitch of 2 cycles on idle rxd (shorter than CLK_PER_HALF_BIT) -> FSM returns to IDLE; count stays 0; no ferr.
- Frame 0x3C with stop bit driven 0 -> ferr pulses exactly 1 cycle; count unchanged. A following valid frame 0x5A is received correctly.
- DEPTH_LOG2=3: send 9 frames with rready=0 -> count=8, ovf pulses once on the 9th. Repeat with rready=1 asserted exactly in the 9th push cycle -> no ovf, count stays 8, 9th byte is at the tail.
- Assert rstn=0 during DATA of a frame, then release -> all outputs at reset values; no spurious byte; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver slice.
//   rx_state_t     : receive FSM state encoding
//   UART_DATA_BITS : data bits per frame (8N1)
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO with wrap-around pointers and an occupancy counter.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   push_i      : write wdata_i (accepted when not full, or when a pop
//                 happens in the same cycle)
//   wdata_i     : byte to write
//   pop_i       : consumer pop request (ignored while empty)
//   rdata_o     : head byte
//   rvalid_o    : FIFO non-empty
//   full_o      : FIFO holds 2**DEPTH_LOG2 entries
//   count_o     : current occupancy
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic                      rvalid_o,
  output logic                      full_o,
  output logic [DEPTH_LOG2:0]       count_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]     wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0]     rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]       count_q, count_d;
  logic                      push_ok, pop_ok;

  assign rvalid_o = (count_q != '0);
  assign full_o   = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign rdata_o  = mem_q[rptr_q];
  assign count_o  = count_q;

  always_comb begin
    pop_ok  = pop_i && rvalid_o;
    // A pop in the same cycle frees the slot the push needs.
    push_ok = push_i && (!full_o || pop_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (pop_ok)  rptr_d = rptr_q + DEPTH_LOG2'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    else if (!push_ok && pop_ok) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_ok) mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO drained via valid/ready.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   rxd       : serial input, idle high, asynchronous to clk
//   rdata     : FIFO head byte, valid when rvalid=1
//   rvalid    : FIFO non-empty
//   rready    : consumer pop (pop when rvalid && rready)
//   count     : FIFO occupancy
//   ferr      : one-cycle pulse, stop bit low, byte discarded
//   ovf       : one-cycle pulse, byte completed while FIFO full, discarded
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 100,
  parameter int unsigned DEPTH_LOG2       = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rdata,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DEPTH_LOG2:0]       count,
  output logic                      ferr,
  output logic                      ovf
);

  localparam int unsigned BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned TW       = $clog2(BIT_CLKS);
  localparam int unsigned BW       = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_END = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_END  = TW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  rx_state_t                 state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      armed_q, armed_d;
  logic                      ferr_q, ferr_d;
  logic                      ovf_q, ovf_d;
  logic                      push;
  logic                      full;

  assign rx_s = sync_q[1];
  assign ferr = ferr_q;
  assign ovf  = ovf_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    // Once the line has been seen high, a low level is a genuine falling edge.
    armed_d = armed_q | rx_s;
    ferr_d  = 1'b0;
    ovf_d   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s && armed_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_END) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + BW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          state_d = IDLE;
          if (rx_s) begin
            push  = 1'b1;
            ovf_d = full && !(rready && rvalid);
          end else begin
            ferr_d  = 1'b1;
            // Line still low: wait for it to go high before the next start.
            armed_d = 1'b0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '1;
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rready),
    .rdata_o (rdata),
    .rvalid_o(rvalid),
    .full_o  (full),
    .count_o (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int CPH  = 4;
  localparam int BITC = 2 * CPH;
  localparam int DL   = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [DL:0] count;
  logic       ferr;
  logic       ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int both_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_count;
    int         exp_ferr;
    int         exp_ovf;
  } vec_t;

  vec_t vecs [4];

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(CPH),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .rxd   (rxd),
    .rdata (rdata),
    .rvalid(rvalid),
    .rready(rready),
    .count (count),
    .ferr  (ferr),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovf) ovf_cnt++;
    if (ferr && ovf) both_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic bit_hold(input logic b);
    rxd = b;
    repeat (BITC) @(negedge clk);
  endtask

  // Drives start + 8 data bits only; returns at the negedge the stop bit begins.
  task automatic send_head(input logic [7:0] d);
    bit_hold(1'b0);
    for (int i = 0; i < 8; i++) bit_hold(d[i]);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    send_head(d);
    bit_hold(stop);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, ".rvalid"}, int'(rvalid), 1);
    check({name, ".rdata"}, int'(rdata), int'(exp));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    int f0, o0;

    vecs[0] = '{8'h01, 1'b1, 1, 0, 0};
    vecs[1] = '{8'h80, 1'b1, 2, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 3, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 4, 0, 0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.rdata", int'(rdata), 0);
    check("rst.rvalid", int'(rvalid), 0);
    check("rst.count", int'(count), 0);
    check("rst.ferr", int'(ferr), 0);
    check("rst.ovf", int'(ovf), 0);
    rstn = 1'b1;
    idle(4);

    // 0xA5 with exact latency: stop driven at N72, sampled at P78, visible at N79
    send_head(8'hA5);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("lat.rvalid_early", int'(rvalid), 0);
    @(negedge clk);
    check("lat.rvalid", int'(rvalid), 1);
    check("lat.rdata", int'(rdata), 8'hA5);
    check("lat.count", int'(count), 1);
    @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("lat.pop_rvalid", int'(rvalid), 0);
    check("lat.pop_count", int'(count), 0);
    idle(3);

    // Back-to-back frames from the table
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].data, vecs[i].stop);
      check($sformatf("b2b[%0d].count", i), int'(count), vecs[i].exp_count);
      check($sformatf("b2b[%0d].ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("b2b[%0d].ovf", i), ovf_cnt - o0, vecs[i].exp_ovf);
    end
    idle(2);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("b2b_pop[%0d]", i), vecs[i].data);
    check("b2b.empty", int'(count), 0);
    check("b2b.rready_empty_rvalid", int'(rvalid), 0);

    // Short low glitch on idle line
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check("glitch.count", int'(count), 0);
    check("glitch.ferr", ferr_cnt - f0, 0);

    // Framing error then a good frame
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    send(8'h3C, 1'b0);
    idle(12);
    check("ferr.pulses", ferr_cnt - f0, 1);
    check("ferr.count", int'(count), 0);
    check("ferr.ovf", ovf_cnt - o0, 0);
    send(8'h5A, 1'b1);
    idle(2);
    pop_expect("ferr_next", 8'h5A);
    check("ferr_next.count", int'(count), 0);

    // Overflow: 9 frames, no pops
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b1);
    idle(2);
    check("ovf.count", int'(count), 8);
    check("ovf.pulses", ovf_cnt - o0, 1);
    check("ovf.ferr", ferr_cnt - f0, 0);
    check("ovf.both", both_cnt, 0);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_pop[%0d]", i), 8'h10 + 8'(i));
    check("ovf.drained", int'(count), 0);

    // Full FIFO with a pop in the 9th push cycle
    o0 = ovf_cnt;
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b1);
    check("fullpop.pre_count", int'(count), 8);
    send_head(8'h28);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    idle(3);
    check("fullpop.count", int'(count), 8);
    check("fullpop.ovf", ovf_cnt - o0, 0);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("fullpop_pop[%0d]", i), 8'h21 + 8'(i));
    check("fullpop.drained", int'(count), 0);

    // Reset in the middle of DATA
    send(8'h11, 1'b1);
    idle(2);
    check("mid.pre_count", int'(count), 1);
    bit_hold(1'b0);
    bit_hold(1'b1);
    bit_hold(1'b0);
    rstn = 1'b0;
    #1;
    check("mid.rst_rvalid", int'(rvalid), 0);
    check("mid.rst_count", int'(count), 0);
    check("mid.rst_rdata", int'(rdata), 0);
    check("mid.rst_ferr", int'(ferr), 0);
    check("mid.rst_ovf", int'(ovf), 0);
    rxd = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    idle(100);
    check("mid.no_spurious", int'(count), 0);
    send(8'hC3, 1'b1);
    idle(2);
    check("mid.count", int'(count), 1);
    pop_expect("mid_next", 8'hC3);
    check("final.both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
